// File: rtl/video_timing_gen.sv
// Raster timing generator running on the oscillator clock with a pixel clock-enable.
// Emits the DAC pixel clock, H/V counters, programmable-polarity syncs, blanking and line/frame pulses.
`timescale 1ns/1ps
module video_timing_gen #(
  parameter int CLKDIV    = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          vo_clk,
  output logic          pix_ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS    = H_ACTIVE + H_FP;
  localparam int H_SE    = H_SS + H_SYNC;
  localparam int V_SS    = V_ACTIVE + V_FP;
  localparam int V_SE    = V_SS + V_SYNC;
  localparam int DW      = $clog2(CLKDIV);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          vo_clk_q, pix_ce_q, hsync_q, vsync_q, blank_n_q;
  logic          line_start_q, frame_start_q;
  logic          adv, h_wrap, v_wrap;
  logic          hs_act_d, vs_act_d, blank_n_d;

  assign adv    = (div_q == DW'(CLKDIV - 1));
  assign h_wrap = (hcount_q == CW'(H_TOTAL - 1));
  assign v_wrap = (vcount_q == CW'(V_TOTAL - 1));

  always_comb begin
    div_d    = adv ? '0 : div_q + DW'(1);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (adv) begin
      hcount_d = h_wrap ? '0 : hcount_q + CW'(1);
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + CW'(1);
      end
    end
  end

  // Decodes look at next-state counters so they line up with the counters they describe.
  assign hs_act_d  = (hcount_d >= CW'(H_SS)) && (hcount_d < CW'(H_SE));
  assign vs_act_d  = (vcount_d >= CW'(V_SS)) && (vcount_d < CW'(V_SE));
  assign blank_n_d = (hcount_d < CW'(H_ACTIVE)) && (vcount_d < CW'(V_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      vo_clk_q      <= 1'b0;
      pix_ce_q      <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      blank_n_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      vo_clk_q      <= (div_d >= DW'(CLKDIV / 2));
      pix_ce_q      <= adv;
      hsync_q       <= hs_act_d ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= vs_act_d ? VSYNC_POL : ~VSYNC_POL;
      blank_n_q     <= blank_n_d;
      line_start_q  <= adv && h_wrap;
      frame_start_q <= adv && h_wrap && v_wrap;
    end
  end

  assign vo_clk      = vo_clk_q;
  assign pix_ce      = pix_ce_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster /2, small raster /3 with inverted syncs, and VGA defaults.
`timescale 1ns/1ps
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_vo, a_pce, a_hs, a_vs, a_bn, a_ls, a_fs;
  logic [10:0] a_h, a_v;
  logic        b_vo, b_pce, b_hs, b_vs, b_bn, b_ls, b_fs;
  logic [10:0] b_h, b_v;
  logic        c_vo, c_pce, c_hs, c_vs, c_bn, c_ls, c_fs;
  logic [10:0] c_h, c_v;

  video_timing_gen #(.CLKDIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(11)) u_a (
    .clk(clk), .rst_n(rst_n), .vo_clk(a_vo), .pix_ce(a_pce), .hcount(a_h), .vcount(a_v),
    .hsync(a_hs), .vsync(a_vs), .blank_n(a_bn), .line_start(a_ls), .frame_start(a_fs));

  video_timing_gen #(.CLKDIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(11)) u_b (
    .clk(clk), .rst_n(rst_n), .vo_clk(b_vo), .pix_ce(b_pce), .hcount(b_h), .vcount(b_v),
    .hsync(b_hs), .vsync(b_vs), .blank_n(b_bn), .line_start(b_ls), .frame_start(b_fs));

  video_timing_gen u_c (
    .clk(clk), .rst_n(rst_n), .vo_clk(c_vo), .pix_ce(c_pce), .hcount(c_h), .vcount(c_v),
    .hsync(c_hs), .vsync(c_vs), .blank_n(c_bn), .line_start(c_ls), .frame_start(c_fs));

  wire [28:0] a_pk = {a_pce, a_vo, a_h, a_v, a_hs, a_vs, a_bn, a_ls, a_fs};
  wire [28:0] b_pk = {b_pce, b_vo, b_h, b_v, b_hs, b_vs, b_bn, b_ls, b_fs};
  wire [28:0] c_pk = {c_pce, c_vo, c_h, c_v, c_hs, c_vs, c_bn, c_ls, c_fs};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int n; int h; int v;
    bit hs; bit vs; bit bn; bit ls; bit fs; bit pce; bit vo;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [28:0] act, input logic [28:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Closed-form expectation n clocks after reset release.
  function automatic logic [28:0] model(int n, int cd, int ha, int hfp, int hsw, int ht,
                                        int va, int vfp, int vsw, int vt, bit hpol, bit vpol);
    int dv, adv, h, v;
    bit pce, vo, hs, vs, bn, ls, fs;
    dv  = n % cd;
    adv = n / cd;
    h   = adv % ht;
    v   = (adv / ht) % vt;
    pce = (n > 0) && (dv == 0);
    vo  = (dv >= cd / 2);
    ls  = pce && (h == 0);
    fs  = ls && (v == 0);
    hs  = ((h >= ha + hfp) && (h < ha + hfp + hsw)) ? hpol : ~hpol;
    vs  = ((v >= va + vfp) && (v < va + vfp + vsw)) ? vpol : ~vpol;
    bn  = (h < ha) && (v < va);
    return {pce, vo, 11'(h), 11'(v), hs, vs, bn, ls, fs};
  endfunction

  function automatic logic [28:0] mod_a(int n);
    return model(n, 2, 8, 2, 3, 14, 4, 1, 2, 8, 1'b0, 1'b0);
  endfunction
  function automatic logic [28:0] mod_b(int n);
    return model(n, 3, 8, 2, 3, 14, 4, 1, 2, 8, 1'b1, 1'b1);
  endfunction
  function automatic logic [28:0] mod_c(int n);
    return model(n, 4, 640, 16, 96, 800, 480, 10, 2, 525, 1'b0, 1'b0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("rasterA", a_pk, mod_a(cyc));
    chk("rasterB", b_pk, mod_b(cyc));
    chk("rasterC", c_pk, mod_c(cyc));
  endtask

  // Reset pattern with syncs idle at the given levels.
  function automatic logic [28:0] rst_pk(bit hs, bit vs);
    return {1'b0, 1'b0, 11'd0, 11'd0, hs, vs, 1'b1, 1'b0, 1'b0};
  endfunction

  initial begin
    tbl[0]  = '{n:0,   h:0,  v:0, hs:1, vs:1, bn:1, ls:0, fs:0, pce:0, vo:0};
    tbl[1]  = '{n:1,   h:0,  v:0, hs:1, vs:1, bn:1, ls:0, fs:0, pce:0, vo:1};
    tbl[2]  = '{n:2,   h:1,  v:0, hs:1, vs:1, bn:1, ls:0, fs:0, pce:1, vo:0};
    tbl[3]  = '{n:16,  h:8,  v:0, hs:1, vs:1, bn:0, ls:0, fs:0, pce:1, vo:0};
    tbl[4]  = '{n:18,  h:9,  v:0, hs:1, vs:1, bn:0, ls:0, fs:0, pce:1, vo:0};
    tbl[5]  = '{n:20,  h:10, v:0, hs:0, vs:1, bn:0, ls:0, fs:0, pce:1, vo:0};
    tbl[6]  = '{n:24,  h:12, v:0, hs:0, vs:1, bn:0, ls:0, fs:0, pce:1, vo:0};
    tbl[7]  = '{n:26,  h:13, v:0, hs:1, vs:1, bn:0, ls:0, fs:0, pce:1, vo:0};
    tbl[8]  = '{n:28,  h:0,  v:1, hs:1, vs:1, bn:1, ls:1, fs:0, pce:1, vo:0};
    tbl[9]  = '{n:29,  h:0,  v:1, hs:1, vs:1, bn:1, ls:0, fs:0, pce:0, vo:1};
    tbl[10] = '{n:56,  h:0,  v:2, hs:1, vs:1, bn:1, ls:1, fs:0, pce:1, vo:0};
    tbl[11] = '{n:84,  h:0,  v:3, hs:1, vs:1, bn:1, ls:1, fs:0, pce:1, vo:0};
    tbl[12] = '{n:112, h:0,  v:4, hs:1, vs:1, bn:0, ls:1, fs:0, pce:1, vo:0};
    tbl[13] = '{n:140, h:0,  v:5, hs:1, vs:0, bn:0, ls:1, fs:0, pce:1, vo:0};
    tbl[14] = '{n:168, h:0,  v:6, hs:1, vs:0, bn:0, ls:1, fs:0, pce:1, vo:0};
    tbl[15] = '{n:196, h:0,  v:7, hs:1, vs:1, bn:0, ls:1, fs:0, pce:1, vo:0};
    tbl[16] = '{n:222, h:13, v:7, hs:1, vs:1, bn:0, ls:0, fs:0, pce:1, vo:0};
    tbl[17] = '{n:224, h:0,  v:0, hs:1, vs:1, bn:1, ls:1, fs:1, pce:1, vo:0};
    tbl[18] = '{n:225, h:0,  v:0, hs:1, vs:1, bn:1, ls:0, fs:0, pce:0, vo:1};

    #1 rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_A", a_pk, rst_pk(1'b1, 1'b1));
    chk("reset_B", b_pk, rst_pk(1'b0, 1'b0));
    chk("reset_C", c_pk, rst_pk(1'b1, 1'b1));

    #3 rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 19; i++) begin
      while (cyc < tbl[i].n) step();
      chk($sformatf("tbl_n%0d", tbl[i].n), a_pk,
          {tbl[i].pce, tbl[i].vo, 11'(tbl[i].h), 11'(tbl[i].v),
           tbl[i].hs, tbl[i].vs, tbl[i].bn, tbl[i].ls, tbl[i].fs});
    end
    while (cyc < 3200) step();

    // Asynchronous assertion mid-cycle must reach the outputs before the next edge.
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_A", a_pk, rst_pk(1'b1, 1'b1));
    chk("async_rst_B", b_pk, rst_pk(1'b0, 1'b0));
    chk("async_rst_C", c_pk, rst_pk(1'b1, 1'b1));
    repeat (10) @(posedge clk);
    #4 rst_n = 1'b1;
    cyc = 0;
    while (cyc < 66) step();
    chk("midframe_pos_A", {18'd0, a_h}, {18'd0, 11'd5});
    chk("midframe_line_A", {18'd0, a_v}, {18'd0, 11'd2});

    #3 rst_n = 1'b0;
    #1;
    chk("midframe_rst_A", a_pk, rst_pk(1'b1, 1'b1));
    chk("midframe_rst_B", b_pk, rst_pk(1'b0, 1'b0));
    chk("midframe_rst_C", c_pk, rst_pk(1'b1, 1'b1));
    repeat (3) @(posedge clk);
    #1;
    chk("held_rst_A", a_pk, rst_pk(1'b1, 1'b1));
    #3 rst_n = 1'b1;
    cyc = 0;
    while (cyc < 3) step();
    chk("first_ce_C_early", {28'd0, c_pce}, 29'd0);
    step();
    chk("first_ce_C", {17'd0, c_pce, c_h}, {17'd0, 1'b1, 11'd1});
    while (cyc < 500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
